// File: rtl/rps_match_ctrl.sv
// rps_match_ctrl: two-player stone/paper/scissors match sequencer.
// Collects one move per player per round over valid/ready handshakes, judges
// the round, keeps the scores and declares a winner at WIN_ROUNDS.
// Optional feature macro: RPS_ROUND_TIMEOUT_EN (awards a round to the player
// who moved when the other stays silent for TIMEOUT_CYCLES cycles).
module rps_match_ctrl #(
    parameter int WIN_ROUNDS     = 3,
    parameter int SCORE_W        = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               p1_valid,
    input  logic [1:0]         p1_move,
    output logic               p1_ready,
    input  logic               p2_valid,
    input  logic [1:0]         p2_move,
    output logic               p2_ready,
    output logic               busy,
    output logic               round_done,
    output logic [1:0]         round_result,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic               match_over,
    output logic [1:0]         match_winner,
    output logic [7:0]         result_char,
    output logic               timeout_flag
);

`ifdef RPS_ROUND_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SCORE_W-1:0] WIN_Q = SCORE_W'(WIN_ROUNDS);
    localparam logic [CNT_W-1:0]   TMO_Q = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        JUDGE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Round judgement: 00 tie, 01 P1, 10 P2, 11 invalid move present.
    function automatic logic [1:0] judge(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] r;
        if ((a == 2'b11) || (b == 2'b11)) begin
            r = 2'b11;
        end else if (a == b) begin
            r = 2'b00;
        end else begin
            case ({a, b})
                4'b0010: r = 2'b01; // stone beats scissors
                4'b0100: r = 2'b01; // paper beats stone
                4'b1001: r = 2'b01; // scissors beats paper
                default: r = 2'b10;
            endcase
        end
        return r;
    endfunction

    // Display code for a round result.
    function automatic logic [7:0] to_char(input logic [1:0] r);
        logic [7:0] c;
        case (r)
            2'b00:   c = 8'd0;
            2'b01:   c = 8'd49;
            2'b10:   c = 8'd50;
            default: c = 8'd63;
        endcase
        return c;
    endfunction

    state_t             state_q, state_d;
    logic               p1_cap_q, p1_cap_d, p2_cap_q, p2_cap_d;
    logic [1:0]         p1_mv_q, p1_mv_d, p2_mv_q, p2_mv_d;
    logic [SCORE_W-1:0] p1_score_q, p1_score_d, p2_score_q, p2_score_d;
    logic [1:0]         round_result_q, round_result_d;
    logic               round_done_q, round_done_d;
    logic [1:0]         match_winner_q, match_winner_d;
    logic [7:0]         result_char_q, result_char_d;
    logic               timeout_flag_q, timeout_flag_d;
    logic               tmo_q, tmo_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               p1_fire_s, p2_fire_s;
    logic [1:0]         res_s;

    assign p1_ready     = (state_q == COLLECT) && !p1_cap_q;
    assign p2_ready     = (state_q == COLLECT) && !p2_cap_q;
    assign busy         = (state_q == COLLECT) || (state_q == JUDGE);
    assign match_over   = (state_q == DONE);
    assign round_done   = round_done_q;
    assign round_result = round_result_q;
    assign p1_score     = p1_score_q;
    assign p2_score     = p2_score_q;
    assign match_winner = match_winner_q;
    assign result_char  = result_char_q;
    assign timeout_flag = timeout_flag_q;

    // Next-state, capture, judging and score update logic.
    always_comb begin
        state_d        = state_q;
        p1_cap_d       = p1_cap_q;
        p2_cap_d       = p2_cap_q;
        p1_mv_d        = p1_mv_q;
        p2_mv_d        = p2_mv_q;
        p1_score_d     = p1_score_q;
        p2_score_d     = p2_score_q;
        round_result_d = round_result_q;
        round_done_d   = 1'b0;
        match_winner_d = match_winner_q;
        timeout_flag_d = timeout_flag_q;
        tmo_d          = tmo_q;
        cnt_d          = cnt_q;
        p1_fire_s      = p1_valid && p1_ready;
        p2_fire_s      = p2_valid && p2_ready;
        res_s          = 2'b00;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    p1_score_d     = '0;
                    p2_score_d     = '0;
                    round_result_d = 2'b00;
                    match_winner_d = 2'b00;
                    timeout_flag_d = 1'b0;
                    p1_cap_d       = 1'b0;
                    p2_cap_d       = 1'b0;
                    tmo_d          = 1'b0;
                    cnt_d          = '0;
                    state_d        = COLLECT;
                end else begin
                    state_d = state_q;
                end
            end
            COLLECT: begin
                if (p1_fire_s) begin
                    p1_cap_d = 1'b1;
                    p1_mv_d  = p1_move;
                end else begin
                    p1_cap_d = p1_cap_q;
                end
                if (p2_fire_s) begin
                    p2_cap_d = 1'b1;
                    p2_mv_d  = p2_move;
                end else begin
                    p2_cap_d = p2_cap_q;
                end
                if (p1_cap_d && p2_cap_d) begin
                    // A capture always wins over an expiring timeout.
                    state_d = JUDGE;
                    cnt_d   = '0;
                end else if (p1_cap_q ^ p2_cap_q) begin
                    cnt_d = cnt_q + 1'b1;
                    if (TMO_EN && (cnt_d == TMO_Q)) begin
                        tmo_d   = 1'b1;
                        state_d = JUDGE;
                    end else begin
                        state_d = COLLECT;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            JUDGE: begin
                if (tmo_q) begin
                    res_s = p1_cap_q ? 2'b01 : 2'b10;
                end else begin
                    res_s = judge(p1_mv_q, p2_mv_q);
                end
                round_done_d   = 1'b1;
                round_result_d = res_s;
                timeout_flag_d = tmo_q;
                if (res_s == 2'b01) begin
                    p1_score_d = p1_score_q + 1'b1;
                end else if (res_s == 2'b10) begin
                    p2_score_d = p2_score_q + 1'b1;
                end else begin
                    p1_score_d = p1_score_q;
                end
                p1_cap_d = 1'b0;
                p2_cap_d = 1'b0;
                tmo_d    = 1'b0;
                cnt_d    = '0;
                if (p1_score_d == WIN_Q) begin
                    match_winner_d = 2'b01;
                    state_d        = DONE;
                end else if (p2_score_d == WIN_Q) begin
                    match_winner_d = 2'b10;
                    state_d        = DONE;
                end else begin
                    state_d = COLLECT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        result_char_d = to_char(round_result_d);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            p1_cap_q       <= 1'b0;
            p2_cap_q       <= 1'b0;
            p1_mv_q        <= 2'b00;
            p2_mv_q        <= 2'b00;
            p1_score_q     <= '0;
            p2_score_q     <= '0;
            round_result_q <= 2'b00;
            round_done_q   <= 1'b0;
            match_winner_q <= 2'b00;
            result_char_q  <= 8'd0;
            timeout_flag_q <= 1'b0;
            tmo_q          <= 1'b0;
            cnt_q          <= '0;
        end else begin
            state_q        <= state_d;
            p1_cap_q       <= p1_cap_d;
            p2_cap_q       <= p2_cap_d;
            p1_mv_q        <= p1_mv_d;
            p2_mv_q        <= p2_mv_d;
            p1_score_q     <= p1_score_d;
            p2_score_q     <= p2_score_d;
            round_result_q <= round_result_d;
            round_done_q   <= round_done_d;
            match_winner_q <= match_winner_d;
            result_char_q  <= result_char_d;
            timeout_flag_q <= timeout_flag_d;
            tmo_q          <= tmo_d;
            cnt_q          <= cnt_d;
        end
    end

endmodule

// File: tb/tb_rps_match_ctrl.sv
// Directed testbench for rps_match_ctrl (default build, timeout feature off).
module tb_rps_match_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       p1_valid = 1'b0, p2_valid = 1'b0;
    logic [1:0] p1_move = 2'b00, p2_move = 2'b00;
    logic       p1_ready, p2_ready, busy, round_done, match_over, timeout_flag;
    logic [1:0] round_result, match_winner;
    logic [2:0] p1_score, p2_score;
    logic [7:0] result_char;

    int n_checks = 0;
    int n_fail   = 0;

    rps_match_ctrl #(.WIN_ROUNDS(3), .SCORE_W(3), .TIMEOUT_CYCLES(255)) dut (
        .clk(clk), .rst(rst), .start(start),
        .p1_valid(p1_valid), .p1_move(p1_move), .p1_ready(p1_ready),
        .p2_valid(p2_valid), .p2_move(p2_move), .p2_ready(p2_ready),
        .busy(busy), .round_done(round_done), .round_result(round_result),
        .p1_score(p1_score), .p2_score(p2_score),
        .match_over(match_over), .match_winner(match_winner),
        .result_char(result_char), .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Offer moves in one cycle, then withdraw; ends right after the capture edge.
    task automatic play(input logic v1, input logic [1:0] m1, input logic v2, input logic [1:0] m2);
        p1_valid = v1; p1_move = m1;
        p2_valid = v2; p2_move = m2;
        tick();
        p1_valid = 1'b0;
        p2_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_rdy"}, {30'd0, p1_ready, p2_ready}, 32'd0);
        check_eq({tag, "_busy"}, busy, 32'd0);
        check_eq({tag, "_rdone"}, round_done, 32'd0);
        check_eq({tag, "_res"}, round_result, 32'd0);
        check_eq({tag, "_s1"}, p1_score, 32'd0);
        check_eq({tag, "_s2"}, p2_score, 32'd0);
        check_eq({tag, "_over"}, match_over, 32'd0);
        check_eq({tag, "_win"}, match_winner, 32'd0);
        check_eq({tag, "_char"}, result_char, 32'd0);
        check_eq({tag, "_tmo"}, timeout_flag, 32'd0);
    endtask

    initial begin
        // Reset state
        #2;
        check_all_zero("reset");
        tick();
        rst = 1'b0;
        tick();
        check_all_zero("idle");

        // 1: stone vs scissors in the same cycle -> P1
        pulse_start();
        check_eq("t1_busy", busy, 32'd1);
        check_eq("t1_rdy", {p1_ready, p2_ready}, 32'd3);
        play(1'b1, 2'b00, 1'b1, 2'b10);
        check_eq("t1_rdy_drop", {p1_ready, p2_ready}, 32'd0);
        check_eq("t1_rdone_early", round_done, 32'd0);
        tick();
        check_eq("t1_rdone", round_done, 32'd1);
        check_eq("t1_res", round_result, 32'd1);
        check_eq("t1_char", result_char, 32'd49);
        check_eq("t1_s1", p1_score, 32'd1);
        check_eq("t1_s2", p2_score, 32'd0);
        tick();
        check_eq("t1_rdone_pulse", round_done, 32'd0);
        check_eq("t1_res_held", round_result, 32'd1);

        // 2: paper then paper 5 cycles later -> tie
        play(1'b1, 2'b01, 1'b0, 2'b00);
        check_eq("t2_rdy", {p1_ready, p2_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            p1_valid = 1'b1; p1_move = 2'b10; // ignored, already captured
            tick();
            check_eq("t2_wait_rdone", round_done, 32'd0);
        end
        p1_valid = 1'b0;
        play(1'b0, 2'b00, 1'b1, 2'b01);
        tick();
        check_eq("t2_rdone", round_done, 32'd1);
        check_eq("t2_res", round_result, 32'd0);
        check_eq("t2_char", result_char, 32'd0);
        check_eq("t2_s1", p1_score, 32'd1);
        check_eq("t2_s2", p2_score, 32'd0);
        tick();

        // 3: invalid move -> 11, replay, no score change
        play(1'b1, 2'b00, 1'b1, 2'b11);
        tick();
        check_eq("t3_res", round_result, 32'd3);
        check_eq("t3_char", result_char, 32'd63);
        check_eq("t3_s1", p1_score, 32'd1);
        check_eq("t3_s2", p2_score, 32'd0);
        tick();
        check_eq("t3_rdy", {p1_ready, p2_ready}, 32'd3);

        // 4: P2 paper beats stone three times -> match to P2
        for (int i = 1; i <= 3; i++) begin
            play(1'b1, 2'b00, 1'b1, 2'b01);
            tick();
            check_eq("t4_rdone", round_done, 32'd1);
            check_eq("t4_res", round_result, 32'd2);
            check_eq("t4_s2", p2_score, i);
            if (i < 3) begin
                tick();
            end
        end
        check_eq("t4_over", match_over, 32'd1);
        check_eq("t4_win", match_winner, 32'd2);
        check_eq("t4_rdy", {p1_ready, p2_ready}, 32'd0);
        check_eq("t4_busy", busy, 32'd0);
        check_eq("t4_char", result_char, 32'd50);
        play(1'b1, 2'b00, 1'b1, 2'b01); // ignored in DONE
        check_eq("t4_hold_s2", p2_score, 32'd3);
        check_eq("t4_hold_rdone", round_done, 32'd0);
        pulse_start();
        check_eq("t4_new_busy", busy, 32'd1);
        check_eq("t4_new_s1", p1_score, 32'd0);
        check_eq("t4_new_s2", p2_score, 32'd0);
        check_eq("t4_new_over", match_over, 32'd0);
        check_eq("t4_new_win", match_winner, 32'd0);
        check_eq("t4_new_res", round_result, 32'd0);

        // 5: reset with P1 captured, P2 pending
        play(1'b1, 2'b10, 1'b0, 2'b00);
        check_eq("t5_rdy", {p1_ready, p2_ready}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("t5_async");
        tick();
        tick();
        check_eq("t5_no_rdone", round_done, 32'd0);
        rst = 1'b0;
        tick();
        check_all_zero("t5_idle");
        // Captured move must have been discarded: P2 alone cannot finish a round.
        pulse_start();
        play(1'b0, 2'b00, 1'b1, 2'b00);
        tick();
        check_eq("t5_discard_rdone", round_done, 32'd0);
        check_eq("t5_discard_rdy", {p1_ready, p2_ready}, 32'd2);
        play(1'b1, 2'b01, 1'b0, 2'b00);
        tick();
        check_eq("t5_after_rdone", round_done, 32'd1);
        check_eq("t5_after_res", round_result, 32'd1);
        check_eq("t5_after_s1", p1_score, 32'd1);
        check_eq("t5_after_tmo", timeout_flag, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rps_match_ctrl.md
Name: rps_match_ctrl

Overview:
Sequencer for a two-player stone/paper/scissors match played over several rounds.
- Collects one move per player per round through valid/ready handshakes.
- Judges each round internally: 00 Stone, 01 Paper, 10 Scissors, 11 invalid.
- Keeps per-player scores and declares the match winner when a player reaches WIN_ROUNDS.
- Sits between player input logic and the display/output mux.

Parameters:
WIN_ROUNDS, 3, round wins needed to take the match (1..2^SCORE_W-1)
SCORE_W, 3, width of each score counter
TIMEOUT_CYCLES, 255, cycles to wait for the second move (used only with the optional feature)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse: clear scores and begin a match
p1_valid  input  1  player 1 move offered
p1_move  input  2  player 1 move
p1_ready  output  1  controller accepts a player 1 move
p2_valid  input  1  player 2 move offered
p2_move  input  2  player 2 move
p2_ready  output  1  controller accepts a player 2 move
busy  output  1  match in progress (COLLECT or JUDGE)
round_done  output  1  one-cycle pulse: round judged
round_result  output  2  00 tie, 01 P1, 10 P2, 11 invalid; held until the next round_done
p1_score  output  SCORE_W  player 1 rounds won
p2_score  output  SCORE_W  player 2 rounds won
match_over  output  1  level: a player has reached WIN_ROUNDS
match_winner  output  2  01 P1, 10 P2, 00 while no winner
result_char  output  8  0 tie, 49 '1', 50 '2', 63 '?'; decoded from round_result
timeout_flag  output  1  last round was decided by timeout

Behaviour:
- Reset (asynchronous): state IDLE. All outputs 0 (result_char 0), both captured-move latches empty.
- IDLE: p1_ready = p2_ready = 0. start -> clear scores, round_result, match_winner and timeout_flag; go to COLLECT.
- COLLECT:
  - pN_ready = 1 while player N's move is not yet captured.
  - Capture happens on pN_valid && pN_ready; pN_ready then drops the next cycle.
  - Further valids from that player are ignored.
  - Both players may be captured in the same cycle.
  - When both moves are held -> JUDGE.
- JUDGE (one cycle):
  - Compute the result. Stone beats Scissors, Paper beats Stone, Scissors beats Paper; equal moves = tie.
  - Either move 11 -> result 11 and no score change; the round is replayed.
  - Winner's score +1; a tie changes no score.
- Round output timing: round_done, round_result and score updates are registered. If the last move is captured at edge N, they are visible after edge N+1, and round_done is high for exactly that one cycle.
- After JUDGE:
  - If the updated score == WIN_ROUNDS -> DONE and set match_winner.
  - Else clear the captured moves and return to COLLECT.
- DONE: match_over = 1, readies 0, scores and match_winner held. start -> new match as from IDLE.
- busy = 1 in COLLECT and JUDGE only.
- start in COLLECT or JUDGE is ignored.
- Reset mid-round discards captured moves and scores.
- Scores never exceed WIN_ROUNDS, so there is no wrap.

Optional Feature:
Macro: RPS_ROUND_TIMEOUT_EN.
- Defined:
  - A counter starts when the first move of a round is captured.
  - It counts cycles while the other move is missing.
  - On reaching TIMEOUT_CYCLES, go to JUDGE with the round awarded to the player who moved. This applies even if that move was 11.
  - round_result = that player, score +1, timeout_flag = 1. timeout_flag clears at the next round_done that is not a timeout.
  - A capture in the same cycle that the counter expires takes priority over the timeout: judge normally.
- Undefined: the controller waits indefinitely; timeout_flag is tied to 0.

Test Plan:
1. Reset, start. P1 Stone (00) and P2 Scissors (10) in the same cycle -> round_done one cycle after capture, round_result 01, result_char 49, p1_score 1.
2. P1 Paper, then P2 Paper 5 cycles later -> p1_ready low after capture, round_result 00, result_char 0, scores unchanged.
3. P2 move 11 with P1 Stone -> round_result 11, result_char 63, no score change, both readies high again next cycle.
4. P2 wins three rounds (Paper vs Stone) -> after the 3rd round_done, match_over 1, match_winner 10, p2_score 3, readies 0. A further start clears scores and busy goes to 1.
5. Assert rst while P1's move is captured and P2's is pending -> all outputs 0 immediately, state IDLE, no round_done.
6. (RPS_ROUND_TIMEOUT_EN, TIMEOUT_CYCLES=4) P1 Scissors, P2 silent -> after 4 cycles round_done, round_result 01, timeout_flag 1, p1_score 1.
